spi_master_ctrl: RTL and testbench

- Host-side SPI master that drives our SPI slave/RAM path over SS_n/MOSI/MISO; all signals synchronous to the shared clk, no separate SCLK.
- Accepts one command per transaction from a host valid/ready interface and serialises the 10-bit frame {op[1:0], payload[7:0]} MSB-first.
- For read-data commands it keeps SS_n low through a turnaround window, then deserialises 8 MISO bits into a one-cycle response.

---
 rtl/spi_master_ctrl.sv | 152 +++++++++++++++
 tb/tb_spi_master_ctrl.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_ctrl.sv
// SPI master controller: accepts one host command per transaction, shifts the
// 10-bit frame {op, payload} out on MOSI MSB-first, and for read-data commands
// waits a turnaround window before assembling 8 MISO bits into a response.
// SS_n and MOSI are flop outputs loaded from the next-state decode, so they
// line up exactly with the state being entered and never glitch.
module spi_master_ctrl #(
  parameter int LEAD_CYCLES = 1,
  parameter int TURNAROUND  = 2,
  parameter int GAP         = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [7:0] cmd_payload,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       busy,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEAD,
    S_SHIFT,
    S_TURN,
    S_SAMPLE,
    S_GAP
  } state_t;

  // Last in-state counter value for each timed state; LEAD_LAST is never
  // consulted when LEAD_CYCLES is zero because LEAD is then skipped.
  localparam logic [3:0] LEAD_LAST  = 4'(LEAD_CYCLES - 1);
  localparam logic [3:0] TURN_LAST  = 4'(TURNAROUND - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP - 1);
  localparam logic [3:0] SHIFT_LAST = 4'd9;
  localparam logic [3:0] SAMPLE_LAST = 4'd7;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic [9:0]  frame;
  logic [9:0]  frame_nxt;
  logic [7:0]  rx_sh;
  logic        ss_n_nxt;
  logic        mosi_nxt;
  logic        sample_done;

  assign cmd_ready   = (state == S_IDLE);
  assign busy        = (state != S_IDLE);
  assign sample_done = (state == S_SAMPLE) && (cnt == SAMPLE_LAST);

  // Next-state, in-state counter and frame capture; the counter restarts at
  // zero on every state change so it never wraps inside a state.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt + 4'd1;
    frame_nxt = frame;
    case (state)
      S_IDLE: begin
        cnt_nxt = 4'd0;
        if (cmd_valid) begin
          frame_nxt = {cmd_op, cmd_payload};
          state_nxt = (LEAD_CYCLES > 0) ? S_LEAD : S_SHIFT;
        end
      end
      S_LEAD: begin
        if (cnt == LEAD_LAST) begin
          state_nxt = S_SHIFT;
          cnt_nxt   = 4'd0;
        end
      end
      S_SHIFT: begin
        if (cnt == SHIFT_LAST) begin
          state_nxt = (frame[9:8] == OP_RD_DATA) ? S_TURN : S_GAP;
          cnt_nxt   = 4'd0;
        end
      end
      S_TURN: begin
        if (cnt == TURN_LAST) begin
          state_nxt = S_SAMPLE;
          cnt_nxt   = 4'd0;
        end
      end
      S_SAMPLE: begin
        if (cnt == SAMPLE_LAST) begin
          state_nxt = S_GAP;
          cnt_nxt   = 4'd0;
        end
      end
      S_GAP: begin
        if (cnt == GAP_LAST) begin
          state_nxt = S_IDLE;
          cnt_nxt   = 4'd0;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Serial line values for the state being entered: select low in the four
  // active states, MOSI carries frame bit (9 - cnt) only while shifting.
  always_comb begin
    ss_n_nxt = 1'b1;
    mosi_nxt = 1'b0;
    if (state_nxt inside {S_LEAD, S_SHIFT, S_TURN, S_SAMPLE}) begin
      ss_n_nxt = 1'b0;
    end
    if (state_nxt == S_SHIFT) begin
      mosi_nxt = frame_nxt[SHIFT_LAST - cnt_nxt];
    end
  end

  // Control and registered outputs; async reset drops SS_n immediately and
  // kills any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= 8'd0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      SS_n      <= ss_n_nxt;
      MOSI      <= mosi_nxt;
      rsp_valid <= sample_done;
      if (sample_done) begin
        rsp_data <= {rx_sh[6:0], MISO};
      end
    end
  end

  // Datapath: latched frame and MISO deserialiser, first sample lands in bit 7.
  always_ff @(posedge clk) begin
    frame <= frame_nxt;
    if (state == S_SAMPLE) begin
      rx_sh <= {rx_sh[6:0], MISO};
    end
  end

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Bench for spi_master_ctrl: instance 0 uses default timing, instance 1 uses
// LEAD_CYCLES=0, TURNAROUND=1, GAP=3. Expected SS_n/MOSI waveforms are built
// per transaction from the frame layout and phase lengths.
module tb_spi_master_ctrl;

  localparam int LP[2] = '{1, 0};
  localparam int TP[2] = '{2, 1};
  localparam int GP[2] = '{1, 3};

  logic            clk;
  logic [1:0]      rst_n;
  logic [1:0]      cmd_valid;
  logic [1:0][1:0] cmd_op;
  logic [1:0][7:0] cmd_payload;
  logic [1:0]      miso;
  wire  [1:0]      cmd_ready;
  wire  [1:0]      rsp_valid;
  wire  [1:0][7:0] rsp_data;
  wire  [1:0]      busy;
  wire  [1:0]      ss_n;
  wire  [1:0]      mosi;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int last_rise[2];
  bit b2b_pending[2];

  spi_master_ctrl #(.LEAD_CYCLES(1), .TURNAROUND(2), .GAP(1)) dut0 (
    .clk(clk), .rst_n(rst_n[0]), .cmd_valid(cmd_valid[0]), .cmd_ready(cmd_ready[0]),
    .cmd_op(cmd_op[0]), .cmd_payload(cmd_payload[0]), .rsp_valid(rsp_valid[0]),
    .rsp_data(rsp_data[0]), .busy(busy[0]), .SS_n(ss_n[0]), .MOSI(mosi[0]), .MISO(miso[0])
  );

  spi_master_ctrl #(.LEAD_CYCLES(0), .TURNAROUND(1), .GAP(3)) dut1 (
    .clk(clk), .rst_n(rst_n[1]), .cmd_valid(cmd_valid[1]), .cmd_ready(cmd_ready[1]),
    .cmd_op(cmd_op[1]), .cmd_payload(cmd_payload[1]), .rsp_valid(rsp_valid[1]),
    .rsp_data(rsp_data[1]), .busy(busy[1]), .SS_n(ss_n[1]), .MOSI(mosi[1]), .MISO(miso[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction on instance idx. abort_at >= 0 asserts reset during that
  // cycle and returns after confirming the abort. With hold set, cmd_valid
  // stays high, inputs are scrambled while busy and the next command (nop,
  // npay) is presented in the IDLE cycle so it is accepted back-to-back.
  task automatic run_txn(input int idx, input logic [1:0] op, input logic [7:0] pay,
                         input logic [7:0] miso_byte, input bit hold,
                         input logic [1:0] nop, input logic [7:0] npay, input int abort_at);
    int L, T, G, n, s0, k;
    bit rd;
    logic [9:0] fr;
    logic exp_ss[$];
    logic exp_mosi[$];
    L  = LP[idx];
    T  = TP[idx];
    G  = GP[idx];
    rd = (op == 2'b11);
    fr = {op, pay};
    repeat (L) begin exp_ss.push_back(1'b0); exp_mosi.push_back(1'b0); end
    for (int b = 9; b >= 0; b--) begin exp_ss.push_back(1'b0); exp_mosi.push_back(fr[b]); end
    if (rd) repeat (T + 8) begin exp_ss.push_back(1'b0); exp_mosi.push_back(1'b0); end
    repeat (G) begin exp_ss.push_back(1'b1); exp_mosi.push_back(1'b0); end
    n  = exp_ss.size();
    s0 = L + 10 + T;

    cmd_valid[idx]   = 1'b1;
    cmd_op[idx]      = op;
    cmd_payload[idx] = pay;
    k = 0;
    while (!cmd_ready[idx] && k < 60) begin @(negedge clk); k++; end
    chk("ready_before_accept", cmd_ready[idx], 1'b1);
    @(posedge clk);
    #1;
    if (!hold) cmd_valid[idx] = 1'b0;

    for (int i = 0; i <= n; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      if (rd && i >= s0 && i < s0 + 8) miso[idx] = miso_byte[7 - (i - s0)];
      else miso[idx] = 1'($urandom);

      if (i == abort_at) begin
        rst_n[idx] = 1'b0;
        #1;
        chk("abort_ss_n", ss_n[idx], 1'b1);
        chk("abort_mosi", mosi[idx], 1'b0);
        chk("abort_busy", busy[idx], 1'b0);
        cmd_valid[idx] = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n[idx] = 1'b1;
        k = 0;
        for (int j = 0; j < 30; j++) begin
          @(negedge clk);
          if (rsp_valid[idx] !== 1'b0 || ss_n[idx] !== 1'b1) k++;
        end
        chk("abort_no_rsp_no_select", k, 0);
        b2b_pending[idx] = 1'b0;
        return;
      end

      if (i == 0 && b2b_pending[idx]) chk("ss_rise_to_fall", cyc - last_rise[idx], G + 1);
      if (i == n - G) last_rise[idx] = cyc;

      if (i < n) begin
        chk($sformatf("ss_n[%0d]", i), ss_n[idx], exp_ss[i]);
        chk($sformatf("mosi[%0d]", i), mosi[idx], exp_mosi[i]);
        chk("busy", busy[idx], 1'b1);
        chk("ready_busy", cmd_ready[idx], 1'b0);
      end else begin
        chk("idle_ss_n", ss_n[idx], 1'b1);
        chk("idle_mosi", mosi[idx], 1'b0);
        chk("idle_busy", busy[idx], 1'b0);
        chk("idle_ready", cmd_ready[idx], 1'b1);
      end
      chk($sformatf("rsp_valid[%0d]", i), rsp_valid[idx], (rd && i == s0 + 8) ? 1'b1 : 1'b0);
      if (rd && i >= s0 + 8) chk("rsp_data", rsp_data[idx], miso_byte);

      if (hold && i < n) begin
        cmd_op[idx]      = 2'($urandom);
        cmd_payload[idx] = 8'($urandom);
      end
      if (hold && i == n) begin
        cmd_op[idx]      = nop;
        cmd_payload[idx] = npay;
      end
    end
    b2b_pending[idx] = hold;
  endtask

  initial begin
    logic [7:0] rb;
    rst_n       = 2'b00;
    cmd_valid   = 2'b00;
    cmd_op      = '0;
    cmd_payload = '0;
    miso        = 2'b00;
    b2b_pending = '{1'b0, 1'b0};
    last_rise   = '{0, 0};
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("rst_ss_n", ss_n[d], 1'b1);
      chk("rst_mosi", mosi[d], 1'b0);
      chk("rst_rsp_valid", rsp_valid[d], 1'b0);
      chk("rst_rsp_data", rsp_data[d], 8'h00);
      chk("rst_busy", busy[d], 1'b0);
    end
    @(negedge clk);
    rst_n = 2'b11;
    @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk("idle_after_rst_ready", cmd_ready[d], 1'b1);
      chk("idle_after_rst_ss_n", ss_n[d], 1'b1);
      chk("idle_after_rst_busy", busy[d], 1'b0);
    end

    // Default timing: write-addr, read-data, back-to-back read pair.
    run_txn(0, 2'b00, 8'hA5, 8'h00, 1'b0, 2'b00, 8'h00, -1);
    run_txn(0, 2'b11, 8'($urandom), 8'h3C, 1'b0, 2'b00, 8'h00, -1);
    run_txn(0, 2'b10, 8'h07, 8'h00, 1'b1, 2'b11, 8'hFF, -1);
    run_txn(0, 2'b11, 8'hFF, 8'h81, 1'b0, 2'b00, 8'h00, -1);

    // Reset during the 5th SHIFT cycle (index LEAD + 4), then a clean read.
    run_txn(0, 2'b11, 8'hC3, 8'hE7, 1'b0, 2'b00, 8'h00, LP[0] + 4);
    chk("rsp_data_cleared_by_rst", rsp_data[0], 8'h00);
    run_txn(0, 2'b11, 8'h96, 8'h4B, 1'b0, 2'b00, 8'h00, -1);
    chk("rsp_data_held", rsp_data[0], 8'h4B);

    // Randomised commands on the default instance.
    for (int r = 0; r < 8; r++) begin
      rb = 8'($urandom);
      run_txn(0, 2'($urandom), 8'($urandom), rb, 1'b0, 2'b00, 8'h00, -1);
    end

    // Alternate timing: no lead, short turnaround, long gap.
    run_txn(1, 2'b11, 8'h00, 8'h5A, 1'b0, 2'b00, 8'h00, -1);
    run_txn(1, 2'b01, 8'h3E, 8'h00, 1'b1, 2'b11, 8'h11, -1);
    run_txn(1, 2'b11, 8'h11, 8'hA6, 1'b0, 2'b00, 8'h00, -1);
    for (int r = 0; r < 4; r++) begin
      rb = 8'($urandom);
      run_txn(1, 2'($urandom), 8'($urandom), rb, 1'b0, 2'b00, 8'h00, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
